// File: rtl/bus_transfer_sequencer_pkg.sv
// Shared constants for the bus transfer sequencer: register codes on both sides
// of the bus, FSM state encoding and the legality check for a code.
package bus_transfer_sequencer_pkg;

    localparam int unsigned MAX_CODE = 23;

    // Source codes, as seen by the 24-input bus encoder
    localparam int unsigned SRC_R0     = 0;
    localparam int unsigned SRC_R15    = 15;
    localparam int unsigned SRC_HI     = 16;
    localparam int unsigned SRC_LO     = 17;
    localparam int unsigned SRC_ZHI    = 18;
    localparam int unsigned SRC_ZLO    = 19;
    localparam int unsigned SRC_PC     = 20;
    localparam int unsigned SRC_MDR    = 21;
    localparam int unsigned SRC_INPORT = 22;
    localparam int unsigned SRC_CSIGN  = 23;

    // Destination codes, one load enable per capturing register
    localparam int unsigned DST_R0      = 0;
    localparam int unsigned DST_R15     = 15;
    localparam int unsigned DST_HI      = 16;
    localparam int unsigned DST_LO      = 17;
    localparam int unsigned DST_PC      = 18;
    localparam int unsigned DST_MDR     = 19;
    localparam int unsigned DST_MAR     = 20;
    localparam int unsigned DST_IR      = 21;
    localparam int unsigned DST_Y       = 22;
    localparam int unsigned DST_OUTPORT = 23;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_XFER  = 2'd1;
    localparam logic [1:0] ST_XFER2 = 2'd2;
    localparam logic [1:0] ST_ERR   = 2'd3;

    function automatic logic codeLegal(input int unsigned code);
        return code <= MAX_CODE;
    endfunction

endpackage

// File: rtl/bus_transfer_sequencer_onehot_decoder.sv
// Enabled code-to-one-hot decoder; codes above MAX_CODE decode to all zeros so
// the upper enable bits can never be driven.
module bus_transfer_sequencer_onehot_decoder
    import bus_transfer_sequencer_pkg::*;
#(
    parameter int SRC_W = 5,
    parameter int EN_W  = 32
) (
    input  logic             enable,
    input  logic [SRC_W-1:0] code,
    output logic [EN_W-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < EN_W; i++) begin
            if (enable && (i <= int'(MAX_CODE)) && (32'(code) == 32'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Destination-side transfer sequencer: turns a (source, destination) request into
// one cycle of source out-enable and destination load-enable, plus the Z pair move.
module bus_transfer_sequencer
    import bus_transfer_sequencer_pkg::*;
#(
    parameter int SRC_W = 5,
    parameter int EN_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SRC_W-1:0] req_src,
    input  logic [SRC_W-1:0] req_dst,
    input  logic             req_pair,
    output logic [EN_W-1:0]  src_oe,
    output logic [EN_W-1:0]  dst_ld,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] xfer_count
);

    logic [1:0]       state;
    logic [1:0]       nextState;
    logic [SRC_W-1:0] latchedSrc;
    logic [SRC_W-1:0] latchedDst;
    logic             latchedPair;
    logic [CNT_W-1:0] xferCount;
    logic             accept;
    logic             inTransfer;
    logic [SRC_W-1:0] srcCode;
    logic [SRC_W-1:0] dstCode;

    assign accept     = (state == ST_IDLE) && req_valid;
    assign inTransfer = (state == ST_XFER) || (state == ST_XFER2);

    // Pair requests bypass the code check since their codes are ignored
    always_comb begin
        nextState = ST_IDLE;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (!req_pair && (!codeLegal(32'(req_src)) || !codeLegal(32'(req_dst)))) begin
                        nextState = ST_ERR;
                    end else begin
                        nextState = ST_XFER;
                    end
                end else begin
                    nextState = ST_IDLE;
                end
            end
            ST_XFER:  nextState = latchedPair ? ST_XFER2 : ST_IDLE;
            ST_XFER2: nextState = ST_IDLE;
            ST_ERR:   nextState = ST_IDLE;
            default:  nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= ST_IDLE;
            latchedSrc  <= '0;
            latchedDst  <= '0;
            latchedPair <= 1'b0;
        end else begin
            state <= nextState;
            if (accept) begin
                latchedSrc  <= req_src;
                latchedDst  <= req_dst;
                latchedPair <= req_pair;
            end
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            xferCount <= '0;
        end else if (inTransfer) begin
            xferCount <= xferCount + CNT_W'(1);
        end
    end

    // The pair move substitutes fixed Z/HI/LO codes for the latched ones
    always_comb begin
        srcCode = latchedSrc;
        dstCode = latchedDst;
        if (state == ST_XFER2) begin
            srcCode = SRC_W'(SRC_ZLO);
            dstCode = SRC_W'(DST_LO);
        end else if (latchedPair) begin
            srcCode = SRC_W'(SRC_ZHI);
            dstCode = SRC_W'(DST_HI);
        end
    end

    bus_transfer_sequencer_onehot_decoder #(
        .SRC_W(SRC_W),
        .EN_W (EN_W)
    ) srcDecoder (
        .enable(inTransfer),
        .code  (srcCode),
        .onehot(src_oe)
    );

    bus_transfer_sequencer_onehot_decoder #(
        .SRC_W(SRC_W),
        .EN_W (EN_W)
    ) dstDecoder (
        .enable(inTransfer),
        .code  (dstCode),
        .onehot(dst_ld)
    );

    assign req_ready  = (state == ST_IDLE);
    assign done       = ((state == ST_XFER) && !latchedPair) || (state == ST_XFER2) || (state == ST_ERR);
    assign err        = (state == ST_ERR);
    assign xfer_count = xferCount;

endmodule

// File: doc/bus_transfer_sequencer.md
# bus_transfer_sequencer

Destination-side companion to the 24-source bus multiplexer. Accepts register-transfer requests (source code, destination code) over a valid/ready handshake. For each request it produces, for exactly one clock cycle, the one-hot 32-bit source out-enable word that drives the bus encoder and the one-hot destination load-enable word that captures the bus value. It also sequences the two-cycle ZHI→HI / ZLO→LO pair move and flags illegal codes.

## Interface
- SRC_W, default 5: source/destination code width.
- EN_W, default 32: one-hot enable word width; must match the encoder input width.
- clock, input, 1: system clock; all state updates on its rising edge.
- clear, input, 1: reset, asynchronous and active-high; forces the idle state and clears all registered outputs.
- req_valid, input, 1: request present.
- req_ready, output, 1: block can accept a request; high only in IDLE.
- req_src, input, SRC_W: source code. 0–15 = R0–R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 InPort, 23 C sign-extended.
- req_dst, input, SRC_W: destination code. 0–15 = R0–R15, 16 HI, 17 LO, 18 PC, 19 MDR, 20 MAR, 21 IR, 22 Y, 23 OutPort.
- req_pair, input, 1: Z pair move. When high, req_src and req_dst are ignored.
- src_oe, output, EN_W: one-hot source out-enable, fed to the bus encoder.
- dst_ld, output, EN_W: one-hot destination load enable.
- done, output, 1: one-cycle pulse, asserted in the final transfer cycle (or the error cycle).
- err, output, 1: asserted with done when the request carried an illegal code.
- xfer_count, output, 16: count of completed legal transfer cycles; wraps modulo 2^16.

## Operation
- **States:** IDLE, XFER, XFER2, ERR.
- **IDLE:**
  - req_ready=1.
  - On req_valid, latch req_src, req_dst and req_pair.
  - Next state is ERR if not pair and (src>23 or dst>23); otherwise XFER.
- **XFER:**
  - Pair request: src_oe bit 18, dst_ld bit 16; next state XFER2.
  - Normal request: src_oe bit src, dst_ld bit dst, done=1; next state IDLE.
- **XFER2:** src_oe bit 19, dst_ld bit 17, done=1; next state IDLE.
- **ERR:** src_oe=0, dst_ld=0, done=1, err=1; next state IDLE. xfer_count does not change.
- **Enable rule:** src_oe and dst_ld are each zero or exactly one-hot; bits 24–31 are always 0.
- **Counter:** xfer_count increments by 1 in every XFER and XFER2 cycle. A pair move adds 2.
- **Legal edge codes:** src==dst is legal. dst=R0 is legal; R0 gating is the register's concern.
- **Request timing:** requests arriving while req_ready=0 are neither accepted nor queued. The initiator holds req_valid.

## Timing
- All outputs are registered state decodes; there are no combinational input→output paths except req_ready, which is a function of state only.
- **Reset:** while clear is high (async), state=IDLE, src_oe=0, dst_ld=0, done=0, err=0, xfer_count=0, req_ready=1 after the first edge-free settle. Deasserting clear resumes in IDLE.
- **Latency:** request accepted at edge N → enables high during cycle N+1 → for a normal request, IDLE at edge N+2.
- **Pair move:** enables in cycles N+1 and N+2; done only in N+2.
- **Throughput:** one normal transfer every 2 cycles, one pair move every 3 cycles.
- **Reset mid-transfer:** enables drop immediately (asynchronously); no done pulse is emitted; the latched request is discarded.

## Structure
- A shared package holds the source-code and destination-code constants (R0…C, HI…OutPort), the state encoding, and MAX_CODE=23.
- One natural sub-module: onehot_decoder (SRC_W→EN_W, with enable). Instantiate it twice, once for src_oe and once for dst_ld, each fed from the state-selected code.

## Test plan
- **Reset:** clear=1 mid-XFER → src_oe=0, dst_ld=0, xfer_count=0 immediately; after release, req_ready=1.
- **Normal transfer:** src=20 (PC), dst=20 (MAR), valid in IDLE → next cycle src_oe=0x0010_0000, dst_ld=0x0010_0000, done=1, err=0; xfer_count 0→1.
- **Pair move:** req_pair=1 → cycle 1: src_oe=0x0004_0000, dst_ld=0x0001_0000, done=0; cycle 2: src_oe=0x0008_0000, dst_ld=0x0002_0000, done=1; xfer_count +2.
- **Illegal codes:** src=25, dst=3 → one cycle with done=1, err=1, src_oe=0, dst_ld=0; xfer_count unchanged. Repeat with src=3, dst=31 for the same result.
- **Back-to-back valid:** req_valid held high for 6 cycles with alternating requests → exactly 3 acceptances; req_ready low in every XFER cycle; no enable word ever has more than one bit set.
- **Counter wrap:** preload by running 65535 transfers, then one more normal transfer → xfer_count=0.
